// File: rtl/stall_controller.sv
// rtl/stall_controller.sv - pipeline stall/flush sequencer with multi-cycle sort handshake
// Zero-latency freeze/flush/bubble decode plus saturating stall statistics.
module stall_controller #(
  parameter int unsigned SORT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             sorthazard,
  input  logic             branch_taken,
  input  logic             sort_done,
  input  logic             stat_clr,
  output logic             freeze_pc,
  output logic             freeze_ifid,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             sort_start,
  output logic             sort_busy,
  output logic             sort_timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_SORT_START = 2'd1,
    ST_SORT_WAIT  = 2'd2,
    ST_SORT_DRAIN = 2'd3
  } state_e;

  localparam logic [15:0]      WAIT_LAST = 16'(SORT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             err_q, err_d;
  logic             err_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      wait_q        <= '0;
      stall_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      stall_count_q <= stall_count_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    err_set     = 1'b0;
    freeze_pc   = 1'b0;
    freeze_ifid = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // A taken branch squashes the wrong-path instruction, so stalling it is pointless.
        if (branch_taken) begin
          flush_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end else if (sorthazard) begin
          freeze_pc   = 1'b1;
          freeze_ifid = 1'b1;
          bubble_idex = 1'b1;
          state_d     = ST_SORT_START;
        end else if (hazard) begin
          freeze_pc   = 1'b1;
          freeze_ifid = 1'b1;
          bubble_idex = 1'b1;
        end
      end
      ST_SORT_START: begin
        freeze_pc   = 1'b1;
        freeze_ifid = 1'b1;
        bubble_idex = 1'b1;
        wait_d      = '0;
        state_d     = ST_SORT_WAIT;
      end
      ST_SORT_WAIT: begin
        freeze_pc   = 1'b1;
        freeze_ifid = 1'b1;
        bubble_idex = 1'b1;
        wait_d      = wait_q + 16'd1;
        if (sort_done) begin
          state_d = ST_SORT_DRAIN;
        end else if (wait_q == WAIT_LAST) begin
          err_set = 1'b1;
          state_d = ST_SORT_DRAIN;
        end
      end
      ST_SORT_DRAIN: begin
        // Release IF/ID but flush it so the sort's successor is fetched again.
        freeze_pc   = 1'b1;
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stat_clr) begin
      stall_count_d = '0;
    end else if (freeze_pc && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (stat_clr) begin
      err_d = 1'b0;
    end
  end

  assign sort_start       = (state_q == ST_SORT_START);
  assign sort_busy        = (state_q != ST_RUN);
  assign sort_timeout_err = err_q;
  assign stall_count      = stall_count_q;

endmodule

// File: tb/tb_stall_controller.sv
// tb/tb_stall_controller.sv - scoreboard bench for stall_controller
// A cycle model pushes expected outputs per driven cycle; they are popped at the falling edge.
module tb_stall_controller;
  localparam int TO     = 8;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          hazard, sorthazard, branch_taken, sort_done, stat_clr;
  logic          freeze_pc, freeze_ifid, flush_ifid, bubble_idex;
  logic          sort_start, sort_busy, sort_timeout_err;
  logic [CW-1:0] stall_count;

  stall_controller #(.SORT_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .sorthazard(sorthazard),
    .branch_taken(branch_taken), .sort_done(sort_done), .stat_clr(stat_clr),
    .freeze_pc(freeze_pc), .freeze_ifid(freeze_ifid), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .sort_start(sort_start), .sort_busy(sort_busy),
    .sort_timeout_err(sort_timeout_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]    ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_st    = 0;
  int   m_wait  = 0;
  int   m_cnt   = 0;
  bit   m_err   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit h, input bit sh, input bit bt, input bit sd, input bit clr);
    bit   fpc, fif, fl, bub, ss, busy, set_err;
    int   nst, nwait;
    exp_t e, got;
    hazard = h; sorthazard = sh; branch_taken = bt; sort_done = sd; stat_clr = clr;
    {fpc, fif, fl, bub, ss, busy, set_err} = '0;
    nst = m_st; nwait = m_wait;
    case (m_st)
      0: if (bt) begin fl = 1; bub = 1; end
         else if (sh) begin fpc = 1; fif = 1; bub = 1; nst = 1; end
         else if (h) begin fpc = 1; fif = 1; bub = 1; end
      1: begin fpc = 1; fif = 1; bub = 1; ss = 1; busy = 1; nwait = 0; nst = 2; end
      2: begin
           fpc = 1; fif = 1; bub = 1; busy = 1; nwait = m_wait + 1;
           if (sd) nst = 3;
           else if (m_wait == TO - 1) begin nst = 3; set_err = 1; end
         end
      default: begin fpc = 1; fl = 1; bub = 1; busy = 1; nst = 0; end
    endcase
    e.ctl = {fpc, fif, fl, bub, ss, busy, m_err};
    e.cnt = CW'(m_cnt);
    sb_q.push_back(e);
    @(negedge clk);
    check_eq("sb_depth", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      got = sb_q.pop_front();
      check_eq("ctl", {freeze_pc, freeze_ifid, flush_ifid, bubble_idex,
                       sort_start, sort_busy, sort_timeout_err}, got.ctl);
      check_eq("cnt", stall_count, got.cnt);
    end
    @(posedge clk);
    m_st = nst; m_wait = nwait;
    if (set_err) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (clr) m_cnt = 0;
    else if (fpc && m_cnt < CNTMAX) m_cnt++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    {hazard, sorthazard, branch_taken, sort_done, stat_clr} = '0;
    #1;
    check_eq("rst_busy", sort_busy, 0);
    check_eq("rst_start", sort_start, 0);
    check_eq("rst_cnt", stall_count, 0);
    check_eq("rst_err", sort_timeout_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    repeat (3) step(1, 0, 0, 0, 0);
    check_eq("haz3_cnt", stall_count, 3);
    step(1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    check_eq("branch_cnt", stall_count, 3);
    check_eq("branch_busy", sort_busy, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);

    step(0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    check_eq("sort_cnt", stall_count, 7);
    step(0, 0, 0, 1, 1);

    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (TO - 1) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check_eq("done_prio_err", sort_timeout_err, 0);

    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (TO) step(0, 0, 0, 0, 0);
    check_eq("timeout_err", sort_timeout_err, 1);
    step(0, 0, 0, 0, 0);
    idle(2);
    check_eq("err_sticky", sort_timeout_err, 1);
    step(0, 0, 0, 0, 1);
    check_eq("err_clr", sort_timeout_err, 0);

    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (TO - 1) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check_eq("set_over_clr", sort_timeout_err, 1);
    step(0, 0, 0, 0, 0);

    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #2;
    hazard = 1'b1;
    rst = 1'b0;
    #1;
    check_eq("arst_busy", sort_busy, 0);
    check_eq("arst_cnt", stall_count, 0);
    check_eq("arst_err", sort_timeout_err, 0);
    check_eq("arst_run_ctl", {freeze_pc, freeze_ifid, flush_ifid, bubble_idex, sort_start}, 5'b11010);
    hazard = 1'b0;
    m_st = 0; m_wait = 0; m_cnt = 0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    repeat (20) step(1, 0, 0, 0, 0);
    check_eq("sat_cnt", stall_count, 15);
    idle(1);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
